// File: rtl/vga_text_writer.sv
// vga_text_writer: turns an ASCII byte stream into glyph writes for the
// 70x30 text console buffer. It keeps a cursor, handles printable bytes,
// newline/carriage return and backspace, and blanks the whole screen after
// reset. Buffer addresses are column-major: {col[6:0], row[4:0]}.
module vga_text_writer #(
    parameter int         COLS  = 70,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    output logic        ch_ready,
    output logic        vmem_we,
    output logic [11:0] vmem_addr,
    output logic [7:0]  vmem_wdata,
    output logic [4:0]  cur_row,
    output logic [6:0]  cur_col,
    output logic        busy
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [6:0] COL_END  = 7'(COLS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [4:0] ROW_END  = 5'(ROWS);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_we;
    logic [11:0] r_addr;
    logic [7:0]  r_wdata;
    logic [4:0]  r_row;
    logic [6:0]  r_col;
    // Column counter shared by the full-screen clear and the single-row clear.
    logic [6:0]  r_k;
    // Row counter of the full-screen clear; reaching ROWS means finished.
    logic [4:0]  r_initRow;
    // Remembers that the character just written moved the cursor to a new row.
    logic        r_advance;

    logic [4:0]  w_nextRow;
    logic [4:0]  w_prevRow;
    logic [6:0]  w_prevCol;
    logic        w_isPrint;
    logic        w_isNewline;
    logic        w_isBackspace;

    // Cursor neighbours and byte classification, used on the acceptance edge.
    always_comb begin
        w_nextRow     = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
        w_prevRow     = r_row - 5'd1;
        w_prevCol     = r_col - 7'd1;
        w_isPrint     = (ch_data >= 8'h20) && (ch_data <= 8'h7E);
        w_isNewline   = (ch_data == 8'h0A) || (ch_data == 8'h0D);
        w_isBackspace = (ch_data == 8'h08);
    end

    // Main controller: screen clear, character acceptance, writes and row clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= INIT;
            r_ready   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 12'd0;
            r_wdata   <= 8'd0;
            r_row     <= 5'd0;
            r_col     <= 7'd0;
            r_k       <= 7'd0;
            r_initRow <= 5'd0;
            r_advance <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_initRow == ROW_END) begin
                        r_we      <= 1'b0;
                        r_ready   <= 1'b1;
                        r_k       <= 7'd0;
                        r_initRow <= 5'd0;
                        r_state   <= IDLE;
                    end else begin
                        r_we    <= 1'b1;
                        r_addr  <= {r_k, r_initRow};
                        r_wdata <= BLANK;
                        if (r_k == LAST_COL) begin
                            r_k       <= 7'd0;
                            r_initRow <= r_initRow + 5'd1;
                        end else begin
                            r_k <= r_k + 7'd1;
                        end
                    end
                end

                IDLE: begin
                    r_we <= 1'b0;
                    if (!r_ready) begin
                        // One-cycle pause after a dropped byte.
                        r_ready <= 1'b1;
                    end else if (ch_valid) begin
                        r_ready <= 1'b0;
                        if (w_isPrint) begin
                            r_we    <= 1'b1;
                            r_addr  <= {r_col, r_row};
                            r_wdata <= ch_data;
                            r_state <= WRITE;
                            if (r_col < LAST_COL) begin
                                r_col     <= r_col + 7'd1;
                                r_advance <= 1'b0;
                            end else begin
                                r_col     <= 7'd0;
                                r_row     <= w_nextRow;
                                r_advance <= 1'b1;
                            end
                        end else if (w_isNewline) begin
                            // The first blank of the new row goes out right away.
                            r_col   <= 7'd0;
                            r_row   <= w_nextRow;
                            r_we    <= 1'b1;
                            r_addr  <= {7'd0, w_nextRow};
                            r_wdata <= BLANK;
                            r_k     <= 7'd1;
                            r_state <= CLEAR;
                        end else if (w_isBackspace && (r_col != 7'd0)) begin
                            r_col     <= w_prevCol;
                            r_we      <= 1'b1;
                            r_addr    <= {w_prevCol, r_row};
                            r_wdata   <= BLANK;
                            r_advance <= 1'b0;
                            r_state   <= WRITE;
                        end else if (w_isBackspace && (r_row != 5'd0)) begin
                            r_row     <= w_prevRow;
                            r_col     <= LAST_COL;
                            r_we      <= 1'b1;
                            r_addr    <= {LAST_COL, w_prevRow};
                            r_wdata   <= BLANK;
                            r_advance <= 1'b0;
                            r_state   <= WRITE;
                        end
                        // Backspace at the origin and unknown bytes are dropped.
                    end
                end

                WRITE: begin
                    if (r_advance) begin
                        r_we    <= 1'b1;
                        r_addr  <= {7'd0, r_row};
                        r_wdata <= BLANK;
                        r_k     <= 7'd1;
                        r_state <= CLEAR;
                    end else begin
                        r_we    <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end

                CLEAR: begin
                    if (r_k == COL_END) begin
                        r_we    <= 1'b0;
                        r_ready <= 1'b1;
                        r_k     <= 7'd0;
                        r_state <= IDLE;
                    end else begin
                        r_we    <= 1'b1;
                        r_addr  <= {r_k, r_row};
                        r_wdata <= BLANK;
                        r_k     <= r_k + 7'd1;
                    end
                end

                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    assign ch_ready   = r_ready;
    assign busy       = !r_ready;
    assign vmem_we    = r_we;
    assign vmem_addr  = r_addr;
    assign vmem_wdata = r_wdata;
    assign cur_row    = r_row;
    assign cur_col    = r_col;

endmodule

// File: tb/tb_vga_text_writer.sv
// tb_vga_text_writer: directed character sequences for vga_text_writer.
// Expected vmem writes go into a queue when a byte is sent; a monitor pops
// and compares them whenever the writer strobes vmem_we.
module tb_vga_text_writer;

   logic        clk;
   logic        rst;
   logic        chValid;
   logic [7:0]  chData;
   logic        chReady;
   logic        vmemWe;
   logic [11:0] vmemAddr;
   logic [7:0]  vmemWdata;
   logic [4:0]  curRow;
   logic [6:0]  curCol;
   logic        busy;

   int compareCount = 0;
   int failCount    = 0;

   logic [19:0] expQ[$];
   logic [11:0] lastAddr;
   logic [11:0] lastCharAddr;
   int          mRow;
   int          mCol;

   vga_text_writer dut (
      .clk        (clk),
      .rst        (rst),
      .ch_valid   (chValid),
      .ch_data    (chData),
      .ch_ready   (chReady),
      .vmem_we    (vmemWe),
      .vmem_addr  (vmemAddr),
      .vmem_wdata (vmemWdata),
      .cur_row    (curRow),
      .cur_col    (curCol),
      .busy       (busy)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: count it, and report a FAIL line when it differs.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pushWrite(input int col, input int row, input logic [7:0] data);
      expQ.push_back({7'(col), 5'(row), data});
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (rst && vmemWe) begin
         lastAddr = vmemAddr;
         if (vmemWdata == 8'h41) lastCharAddr = vmemAddr;
         if (expQ.size() == 0) begin
            compareCount++;
            failCount++;
            $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     vmemAddr, vmemWdata);
         end else begin
            logic [19:0] exp;
            exp = expQ.pop_front();
            checkOutput("write_addr", 32'(vmemAddr), 32'(exp[19:8]));
            checkOutput("write_data", 32'(vmemWdata), 32'(exp[7:0]));
         end
      end
   end

   // Release reset and follow the full-screen clear until ch_ready rises.
   task automatic releaseAndInit(input string tag);
      int n;
      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 70; c++)
            pushWrite(c, r, 8'h20);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      while (n < 2300) begin
         @(negedge clk);
         n++;
         if (n == 1)    checkOutput({tag, "_first_addr"},  32'(vmemAddr), 32'h000);
         if (n == 2)    checkOutput({tag, "_second_addr"}, 32'(vmemAddr), 32'h020);
         if (n == 2100) checkOutput({tag, "_last_addr"},   32'(vmemAddr), 32'h8BD);
         if (chReady) break;
      end
      checkOutput({tag, "_ready_cycle"}, 32'(n), 32'd2101);
      checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'd0);
      checkOutput({tag, "_cursor"}, 32'({curRow, curCol}), 32'd0);
      mRow = 0;
      mCol = 0;
   endtask

   task automatic waitReady(input string tag);
      int n;
      n = 0;
      while (!chReady && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!chReady) begin
         compareCount++;
         failCount++;
         $display("[TB] FAIL %s_ready_timeout: got ch_ready 0, expected 1", tag);
      end
   endtask

   // Send one byte: queue its expected writes, hand it over, then check
   // ready latency, final cursor and that every expected write arrived.
   task automatic applyStimulus(input logic [7:0] c, input string tag);
      int  expGap;
      int  gap;
      bit  adv;
      expGap = 2;
      adv    = 1'b0;
      waitReady(tag);
      if (c >= 8'h20 && c <= 8'h7E) begin
         pushWrite(mCol, mRow, c);
         if (mCol < 69) mCol++;
         else begin
            mCol   = 0;
            adv    = 1'b1;
            expGap = 72;
         end
      end else if (c == 8'h0A || c == 8'h0D) begin
         mCol   = 0;
         adv    = 1'b1;
         expGap = 71;
      end else if (c == 8'h08) begin
         if (mCol > 0) begin
            mCol--;
            pushWrite(mCol, mRow, 8'h20);
         end else if (mRow > 0) begin
            mRow--;
            mCol = 69;
            pushWrite(mCol, mRow, 8'h20);
         end
      end
      if (adv) begin
         mRow = (mRow == 29) ? 0 : mRow + 1;
         for (int k = 0; k < 70; k++) pushWrite(k, mRow, 8'h20);
      end
      chValid = 1'b1;
      chData  = c;
      @(posedge clk);
      #1;
      chValid = 1'b0;
      chData  = 8'h00;
      gap = 0;
      while (gap < 300) begin
         @(negedge clk);
         gap++;
         if (chReady) break;
      end
      checkOutput({tag, "_ready_gap"}, 32'(gap), 32'(expGap));
      checkOutput({tag, "_row"}, 32'(curRow), 32'(mRow));
      checkOutput({tag, "_col"}, 32'(curCol), 32'(mCol));
      checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'd0);
   endtask

   // Directed sequence following the test plan.
   initial begin
      rst          = 1'b0;
      chValid      = 1'b0;
      chData       = 8'h00;
      lastAddr     = 12'd0;
      lastCharAddr = 12'd0;
      mRow         = 0;
      mCol         = 0;

      #12;
      checkOutput("reset_ready", 32'(chReady), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd1);
      checkOutput("reset_we", 32'(vmemWe), 32'd0);
      checkOutput("reset_addr", 32'(vmemAddr), 32'd0);
      checkOutput("reset_wdata", 32'(vmemWdata), 32'd0);
      checkOutput("reset_cursor", 32'({curRow, curCol}), 32'd0);

      releaseAndInit("init");
      checkOutput("idle_busy", 32'(busy), 32'd0);

      // Single printable character at the origin.
      applyStimulus(8'h42, "char_B");
      checkOutput("char_B_addr", 32'(lastAddr), 32'h000);
      checkOutput("char_B_cursor", 32'({curRow, curCol}), 32'({5'd0, 7'd1}));

      // Step back to the origin, then fill row 0 to force a wrap.
      applyStimulus(8'h08, "bs_to_origin");
      for (int i = 0; i < 70; i++) applyStimulus(8'h41, "wrap_A");
      checkOutput("wrap_last_char_addr", 32'(lastCharAddr), 32'h8A0);
      checkOutput("wrap_last_clear_addr", 32'(lastAddr), 32'h8A1);
      checkOutput("wrap_cursor", 32'({curRow, curCol}), 32'({5'd1, 7'd0}));

      // Backspace across a row boundary.
      applyStimulus(8'h0A, "nl_to_row2");
      applyStimulus(8'h08, "bs_row_back");
      checkOutput("bs_row_back_addr", 32'(lastAddr), 32'h8A1);
      checkOutput("bs_row_back_cursor", 32'({curRow, curCol}), 32'({5'd1, 7'd69}));

      // Walk down to (29,5) and wrap to the top with a newline.
      applyStimulus(8'h0D, "cr_to_row2");
      for (int i = 0; i < 27; i++) applyStimulus(8'h0A, "nl_walk");
      for (int i = 0; i < 5; i++) applyStimulus(8'h61 + 8'(i), "row29_text");
      checkOutput("row29_cursor", 32'({curRow, curCol}), 32'({5'd29, 7'd5}));
      applyStimulus(8'h0A, "nl_bottom_wrap");
      checkOutput("bottom_wrap_cursor", 32'({curRow, curCol}), 32'd0);
      checkOutput("bottom_wrap_last_addr", 32'(lastAddr), 32'(12'd69 * 12'd32));

      // Bytes that are accepted but produce nothing.
      applyStimulus(8'h08, "bs_at_origin");
      applyStimulus(8'h07, "drop_bell");
      applyStimulus(8'h7F, "drop_del");
      checkOutput("drop_cursor", 32'({curRow, curCol}), 32'd0);

      // Reset during the 30th write of a row clear.
      waitReady("mid_clear");
      for (int k = 0; k < 30; k++) pushWrite(k, 1, 8'h20);
      chValid = 1'b1;
      chData  = 8'h0A;
      @(posedge clk);
      #1;
      chValid = 1'b0;
      chData  = 8'h00;
      repeat (30) @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("mid_clear_we", 32'(vmemWe), 32'd0);
      checkOutput("mid_clear_cursor", 32'({curRow, curCol}), 32'd0);
      checkOutput("mid_clear_ready", 32'(chReady), 32'd0);
      checkOutput("mid_clear_pending", 32'(expQ.size()), 32'd0);
      expQ.delete();
      releaseAndInit("reinit");

      applyStimulus(8'h5A, "after_reinit");
      checkOutput("after_reinit_addr", 32'(lastAddr), 32'h000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
